// File: rtl/gate_sweep_checker.sv
// Sweeps every N-bit vector into an external gate, holding each for STEP cycles,
// and counts responses that disagree with the selected reference gate function.
module gate_sweep_checker #(
  parameter int N    = 3,
  parameter int STEP = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   mode,
  output logic [N-1:0] vec_out,
  input  logic         dut_y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic         first_err_valid,
  output logic [N-1:0] first_err_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int            SW        = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] step_q;
  logic [2:0]    mode_q;
  logic          expected, launch, compare, last_vec, mismatch;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (compare && last_vec) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Reference gate function and per-cycle control strobes.
  always_comb begin
    expected = 1'b0;
    case (mode_q)
      3'd0: expected = &vec_out;
      3'd1: expected = |vec_out;
      3'd2: expected = ^vec_out;
      3'd3: expected = ~&vec_out;
      3'd4: expected = ~|vec_out;
      3'd5: expected = ~^vec_out;
      3'd6: expected = vec_out[0];
      3'd7: expected = ~vec_out[0];
      default: expected = 1'b0;
    endcase
    launch   = start && (state_q != RUN);
    compare  = (state_q == RUN) && (step_q == STEP_LAST);
    last_vec = (vec_out == '1);
    mismatch = compare && (dut_y != expected);
  end

  // Registered datapath and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q          <= '0;
      step_q          <= '0;
      vec_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (launch) begin
      mode_q          <= mode;
      step_q          <= '0;
      vec_out         <= '0;
      busy            <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (state_q == RUN) begin
      if (compare) begin
        step_q <= '0;
        if (mismatch) begin
          err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= vec_out;
          end
        end
        // The final compare and the transition to DONE share one edge.
        if (last_vec) begin
          vec_out <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_count == '0) && !mismatch;
        end else begin
          vec_out <= vec_out + 1'b1;
        end
      end else begin
        step_q <= step_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench for gate_sweep_checker (N=3, STEP=2): directed vector
// table, multi-cycle corner sequences and randomized sweeps against a model.
module tb_gate_sweep_checker;

  localparam int N      = 3;
  localparam int STEP   = 2;
  localparam int NVEC   = 1 << N;
  localparam int SWEEP  = NVEC * STEP;

  logic         clk = 1'b0;
  logic         rst_n, start, dut_y;
  logic [2:0]   mode;
  logic [N-1:0] vec_out, first_err_vec;
  logic         busy, done, pass, first_err_valid;
  logic [N:0]   err_count;
  logic [7:0]   resp_table;

  int n_checks = 0;
  int n_passed = 0;

  gate_sweep_checker #(.N(N), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_out(vec_out),
    .dut_y(dut_y), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  // Emulated external gate: an arbitrary truth table indexed by the stimulus.
  always_comb dut_y = resp_table[vec_out];

  typedef struct {
    logic [2:0] m;
    logic [7:0] tbl;
    int         e_err;
    logic       e_fv;
    logic [2:0] e_fvec;
  } vec_rec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  function automatic logic gold(input logic [2:0] m, input int v);
    logic all_one, any_one, odd;
    all_one = (v == NVEC - 1);
    any_one = (v != 0);
    odd     = ($countones(v) % 2) == 1;
    case (m)
      3'd0: return all_one;
      3'd1: return any_one;
      3'd2: return odd;
      3'd3: return !all_one;
      3'd4: return !any_one;
      3'd5: return !odd;
      3'd6: return (v % 2) == 1;
      default: return (v % 2) == 0;
    endcase
  endfunction

  task automatic model(input logic [2:0] m, input logic [7:0] tbl,
                       output int err, output logic fv, output logic [2:0] fvec);
    err = 0; fv = 1'b0; fvec = '0;
    for (int v = 0; v < NVEC; v++) begin
      if (tbl[v] != gold(m, v)) begin
        err++;
        if (!fv) begin fv = 1'b1; fvec = 3'(v); end
      end
    end
  endtask

  // One full sweep; optional start pulses (with a changed mode) at cycles pa/pb.
  task automatic run_sweep(input string tag, input logic [2:0] m, input logic [7:0] tbl,
                           input int e_err, input logic e_fv, input logic [2:0] e_fvec,
                           input int pa, input int pb);
    logic [31:0] final_exp;
    resp_table = tbl;
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = 3'($urandom_range(0, 7));
    for (int j = 0; j < SWEEP; j++) begin
      if (j > 0) @(negedge clk);
      check({tag, " run"}, {busy, done, pass, 5'(vec_out)}, {1'b1, 1'b0, 1'b0, 5'(j / STEP)});
      if (j == pa || j == pb) begin start = 1'b1; mode = m ^ 3'd1; end
      else start = 1'b0;
    end
    @(negedge clk); start = 1'b0;
    final_exp = {busy, done, pass, 5'(vec_out), 5'(err_count), first_err_valid, 4'(first_err_vec)};
    check({tag, " done"}, final_exp,
          {1'b0, 1'b1, (e_err == 0), 5'd0, 5'(e_err), e_fv, 4'(e_fvec)});
    repeat (3) @(negedge clk);
    check({tag, " hold"},
          {busy, done, pass, 5'(vec_out), 5'(err_count), first_err_valid, 4'(first_err_vec)},
          final_exp);
  endtask

  vec_rec_t recs[13];
  int       r_err;
  logic     r_fv;
  logic [2:0] r_fvec;
  bit       saw_done;

  initial begin
    recs[0]  = '{3'd0, 8'h80, 0, 1'b0, 3'd0};  // AND, correct gate
    recs[1]  = '{3'd0, 8'h00, 1, 1'b1, 3'd7};  // AND, stuck-at-0: last vector only
    recs[2]  = '{3'd2, 8'h00, 4, 1'b1, 3'd1};  // XOR, stuck-at-0
    recs[3]  = '{3'd7, 8'h55, 0, 1'b0, 3'd0};  // NOT, correct (restart from DONE)
    recs[4]  = '{3'd1, 8'hFF, 1, 1'b1, 3'd0};  // OR, stuck-at-1: first vector only
    recs[5]  = '{3'd3, 8'hFF, 1, 1'b1, 3'd7};  // NAND, stuck-at-1
    recs[6]  = '{3'd4, 8'h00, 1, 1'b1, 3'd0};  // NOR, stuck-at-0
    recs[7]  = '{3'd5, 8'h00, 4, 1'b1, 3'd0};  // XNOR, stuck-at-0
    recs[8]  = '{3'd6, 8'hAA, 0, 1'b0, 3'd0};  // BUF, correct
    recs[9]  = '{3'd6, 8'h00, 4, 1'b1, 3'd1};  // BUF, stuck-at-0
    recs[10] = '{3'd1, 8'h00, 7, 1'b1, 3'd1};  // OR, stuck-at-0
    recs[11] = '{3'd2, 8'hFF, 4, 1'b1, 3'd0};  // XOR, stuck-at-1
    recs[12] = '{3'd0, 8'h7F, 8, 1'b1, 3'd0};  // every vector wrong: full-scale count

    rst_n = 1'b0; start = 1'b0; mode = 3'd0; resp_table = 8'h00;
    repeat (2) @(negedge clk);
    check("reset state", {busy, done, pass, 5'(vec_out), 5'(err_count), first_err_valid, 4'(first_err_vec)}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle without start", {busy, done, 5'(vec_out)}, 32'd0);

    foreach (recs[i])
      run_sweep($sformatf("vec%0d", i), recs[i].m, recs[i].tbl,
                recs[i].e_err, recs[i].e_fv, recs[i].e_fvec, -1, -1);

    // Start pulses mid-sweep with mode switched to OR must be ignored.
    run_sweep("start ignored", 3'd0, 8'h80, 0, 1'b0, 3'd0, 3, 9);

    // Reset mid-sweep aborts and discards partial results.
    resp_table = 8'h00;
    @(negedge clk); start = 1'b1; mode = 3'd2;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    check("errors before abort", 32'(err_count != 0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("abort clears", {busy, done, pass, 5'(vec_out), 5'(err_count), first_err_valid, 4'(first_err_vec)}, 32'd0);
    saw_done = 1'b0;
    repeat (SWEEP + 4) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("stays idle after abort", 32'(saw_done), 32'd0);

    // Reset wins over a simultaneous start.
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    check("reset beats start", {busy, done}, 32'd0);

    for (int k = 0; k < 20; k++) begin
      logic [2:0] m;
      logic [7:0] tbl;
      m   = 3'($urandom_range(0, 7));
      tbl = 8'($urandom);
      model(m, tbl, r_err, r_fv, r_fvec);
      run_sweep($sformatf("rand%0d m=%0d t=%02h", k, m, tbl), m, tbl, r_err, r_fv, r_fvec, -1, -1);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
